// File: rtl/sipo_pkg.sv
// Shared types and width helpers for the sipo_rx serial receiver.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int N_DEF      = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = $clog2(N_DEF);
    localparam int BIT_W      = $clog2(DATA_W_DEF);

    // Counter width for a given range; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sipo_bit_timer.sv
// Baud down-counter: load/reload on request, 1-cycle sample tick while the count is zero.
module sipo_bit_timer
    import sipo_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/sipo_rx.sv
// Framed serial receiver (start, DATA_W bits LSB first, stop), mid-bit sampled at N clocks/bit.
// Optional input synchronizer enabled by defining SIPO_SYNC_EN.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = width_of(N);
    localparam int BW = width_of(DATA_W);
    localparam logic [CW-1:0] HALF_M1 = CW'(N / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(N - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic              din_s;
    logic              din_prev_q;
    state_t            state_q;
    logic [BW-1:0]     bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;
    logic              ferr_q;
    logic              start_det;
    logic              tick;
    logic              timer_load;
    logic [CW-1:0]     timer_val;

`ifdef SIPO_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Reset to the idle level so leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    assign din_s = sync2_q;
`else
    assign din_s = din;
`endif

    assign start_det  = (state_q == IDLE) && din_prev_q && !din_s;
    assign timer_load = start_det || (tick && (state_q == START || state_q == DATA));
    assign timer_val  = start_det ? HALF_M1 : FULL_M1;

    sipo_bit_timer #(
        .W(CW)
    ) u_timer (
        .clk       (clk),
        .rst_ni    (rst),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .tick_o    (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            din_prev_q <= 1'b1;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            din_prev_q <= din_s;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_det) state_q <= START;
                end
                START: begin
                    if (tick) begin
                        // A start bit that is high again at mid-bit was only a glitch.
                        if (!din_s) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q[bit_idx_q] <= din_s;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (din_s) begin
                            dout_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_rx.sv
// Directed self-checking bench for sipo_rx (N=8, DATA_W=8); honours SIPO_SYNC_EN for timing.
module tb_sipo_rx;

    localparam int N      = 8;
    localparam int DATA_W = 8;
`ifdef SIPO_SYNC_EN
    localparam int SH = 2;
`else
    localparam int SH = 0;
`endif
    localparam int LAT = N / 2 + (DATA_W + 1) * N + 1 + SH;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              din = 1'b1;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              frame_err;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int both_hi = 0;

    int v_cyc[$];
    int v_dat[$];
    int v_busy[$];
    int f_cyc[$];
    int e0_q[$];

    sipo_rx #(
        .N     (N),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .dout     (dout),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulses are logged with the edge at which a consumer would sample them.
    always @(negedge clk) begin
        if (valid) begin
            v_cyc.push_back(cyc + 1);
            v_dat.push_back(int'(dout));
            v_busy.push_back(int'(busy));
            $display("[TB] rx byte 0x%02h at cycle %0d", dout, cyc + 1);
        end
        if (frame_err) begin
            f_cyc.push_back(cyc + 1);
            $display("[TB] frame error at cycle %0d", cyc + 1);
        end
        if (valid && frame_err) both_hi <= both_hi + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance n posedges and settle 1 time unit past the last one.
    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        v_cyc.delete();
        v_dat.delete();
        v_busy.delete();
        f_cyc.delete();
        e0_q.delete();
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input logic stop_bit);
        e0_q.push_back(cyc + 1);
        din = 1'b0;
        tick_n(N);
        for (int i = 0; i < DATA_W; i++) begin
            din = data[i];
            tick_n(N);
        end
        din = stop_bit;
        tick_n(N);
    endtask

    initial begin
        logic [DATA_W-1:0] bytes [5];
        int e0;

        // 1: reset behaviour
        tick_n(3);
        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        tick_n(5);
        check("idle_busy", int'(busy), 0);
        check("idle_valid", int'(valid), 0);

        // 2: single byte 0xA5
        clear_logs();
        send_frame(8'hA5, 1'b1);
        din = 1'b1;
        tick_n(6);
        check("a5_count", v_cyc.size(), 1);
        check("a5_latency", v_cyc[0] - e0_q[0], LAT);
        check("a5_data", v_dat[0], 8'hA5);
        check("a5_busy_at_valid", v_busy[0], 0);
        check("a5_ferr", f_cyc.size(), 0);
        check("a5_dout_hold", int'(dout), 8'hA5);

        // 3: five bytes back to back
        clear_logs();
        for (int i = 0; i < 5; i++) bytes[i] = DATA_W'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b1);
        din = 1'b1;
        tick_n(6);
        check("b2b_count", v_cyc.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < v_cyc.size()) begin
                check($sformatf("b2b_data%0d", i), v_dat[i], int'(bytes[i]));
                check($sformatf("b2b_latency%0d", i), v_cyc[i] - e0_q[i], LAT);
                if (i > 0) check($sformatf("b2b_spacing%0d", i), v_cyc[i] - v_cyc[i-1], 10 * N);
            end
        end

        // 4: bad stop bit, line left low afterwards
        clear_logs();
        send_frame(8'h3C, 1'b0);
        tick_n(20);
        check("ferr_count", f_cyc.size(), 1);
        check("ferr_latency", f_cyc[0] - e0_q[0], LAT);
        check("ferr_valid", v_cyc.size(), 0);
        check("ferr_dout_held", int'(dout), int'(bytes[4]));
        check("ferr_low_no_restart", int'(busy), 0);
        din = 1'b1;
        tick_n(4);

        // 5: two-cycle low glitch
        clear_logs();
        e0 = cyc + 1;
        din = 1'b0;
        tick_n(2);
        din = 1'b1;
        tick_n(2 + SH);
        check("glitch_busy_mid", int'(busy), 1);
        tick_n(1);
        check("glitch_idle_at_e0p4", int'(busy), 0);
        check("glitch_elapsed", cyc - e0, 4 + SH);
        tick_n(20);
        check("glitch_valid", v_cyc.size(), 0);
        check("glitch_ferr", f_cyc.size(), 0);

        // 6: reset mid-DATA, then clean 0x81
        clear_logs();
        din = 1'b0;
        tick_n(N);
        din = 1'b1;
        tick_n(2 * N);
        check("abort_busy_before", int'(busy), 1);
        rst = 1'b0;
        tick_n(2);
        check("abort_dout_zero", int'(dout), 0);
        check("abort_busy", int'(busy), 0);
        rst = 1'b1;
        tick_n(3);
        send_frame(8'h81, 1'b1);
        din = 1'b1;
        tick_n(6);
        check("after_abort_count", v_cyc.size(), 1);
        check("after_abort_data", v_dat[0], 8'h81);
        check("after_abort_latency", v_cyc[0] - e0_q[0], LAT);
        check("after_abort_ferr", f_cyc.size(), 0);

        check("valid_ferr_overlap", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
